// File: rtl/udp_tx_sched.sv
// Frame launch scheduler between the ADC sample FIFO and the UDP TX engine:
// full frames when available, timed flush of a stale remainder, done watchdog.
module udp_tx_sched #(
  parameter int PKT_LEN       = 1024,
  parameter int CNT_W         = 11,
  parameter int FLUSH_TIMEOUT = 125000,
  parameter int START_W       = 4,
  parameter int IFG_CYCLES    = 12,
  parameter int DONE_TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] fifo_cnt,
  input  logic             tx_done,
  output logic             tx_start_en,
  output logic [15:0]      tx_byte_num,
  output logic             busy,
  output logic [31:0]      pkt_cnt,
  output logic             err_timeout,
  output logic [15:0]      err_cnt
);
  localparam int PH_MAX = (START_W > IFG_CYCLES) ? START_W : IFG_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int FT_W   = $clog2(FLUSH_TIMEOUT + 1);
  localparam int WD_W   = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] PKT_LEN_C  = CNT_W'(PKT_LEN);
  localparam logic [FT_W-1:0]  FLUSH_C    = FT_W'(FLUSH_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_W - 1);
  localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [FT_W-1:0] flush_q, flush_d;
  logic            tx_start_en_q, tx_start_en_d;
  logic [15:0]     byte_q, byte_d;
  logic            busy_q, busy_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic            err_timeout_q, err_timeout_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    wd_d          = wd_q;
    flush_d       = '0;
    byte_d        = byte_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_timeout_d = 1'b0;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        ph_d = '0;
        wd_d = '0;
        if (en && fifo_cnt >= PKT_LEN_C) begin
          state_d = S_START;
          byte_d  = 16'(PKT_LEN);
        end else if (en && fifo_cnt != '0 && flush_q == FLUSH_C) begin
          state_d = S_START;
          byte_d  = 16'(fifo_cnt);
        end else if (en && fifo_cnt != '0) begin
          // reaching FLUSH_TIMEOUT always launches, so this never overruns
          flush_d = flush_q + 1'b1;
        end
        // the launch cycle itself counts toward the watchdog
        if (state_d == S_START) wd_d = WD_W'(1);
      end

      S_START, S_WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        if (tx_done) begin
          state_d   = S_GAP;
          ph_d      = '0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else if (wd_q == WD_LAST) begin
          state_d       = S_GAP;
          ph_d          = '0;
          err_timeout_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else if (state_q == S_START) begin
          if (ph_q == START_LAST) state_d = S_WAIT_DONE;
          ph_d = ph_q + 1'b1;
        end
      end

      S_GAP: begin
        if (ph_q == GAP_LAST) state_d = S_IDLE;
        ph_d = ph_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    tx_start_en_d = (state_d == S_START);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      wd_q          <= '0;
      flush_q       <= '0;
      tx_start_en_q <= 1'b0;
      byte_q        <= '0;
      busy_q        <= 1'b0;
      pkt_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      wd_q          <= wd_d;
      flush_q       <= flush_d;
      tx_start_en_q <= tx_start_en_d;
      byte_q        <= byte_d;
      busy_q        <= busy_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign tx_start_en = tx_start_en_q;
  assign tx_byte_num = byte_q;
  assign busy        = busy_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_timeout = err_timeout_q;
  assign err_cnt     = err_cnt_q;
endmodule
